// File: rtl/quad_cmd_pkg.sv
// quad_cmd_pkg: shared definitions for the quadcopter command link --
// receive frame states, frame length, opcodes and the positive acknowledge.
package quad_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } frame_state_e;

  localparam int FRAME_BYTES = 3;

  localparam logic [7:0] CMD_REQ_BATT  = 8'h01;
  localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
  localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
  localparam logic [7:0] CMD_SET_YAW   = 8'h04;
  localparam logic [7:0] CMD_SET_THRST = 8'h05;
  localparam logic [7:0] CMD_CALIBRATE = 8'h06;
  localparam logic [7:0] CMD_EMER_LAND = 8'h07;
  localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_frame_timer.sv
// cmd_frame_timer: inter-byte idle counter for a partially received frame.
// Counts clocks while a frame is open; expired is high in the cycle the
// count reaches TIMEOUT_CYCLES-1. Only instantiated when the build defines
// CMD_FRAME_TIMEOUT_EN.
module cmd_frame_timer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,      // a frame is open (receiver not in IDLE)
  input  logic clr,      // a byte is being accepted this cycle
  output logic expired
);

  localparam logic [23:0] LIMIT = TIMEOUT_CYCLES - 24'd1;

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  assign expired = run && (cnt_q == LIMIT);

  // Restart on every accepted byte, while idle, and on expiry; else count up.
  always_comb begin
    cnt_d = cnt_q + 24'd1;
    if (!run || clr || expired) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_frame_rcv.sv
// cmd_frame_rcv: assembles 3-byte command frames (opcode, data hi, data lo)
// from a byte UART and forwards single response bytes back to it.
// Optional inter-byte timeout: define CMD_FRAME_TIMEOUT_EN.
module cmd_frame_rcv
  import quad_cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        resp_sent,
  output logic        frm_err
);

  frame_state_e state_q, state_d;
  logic [7:0]   op_q, op_d;       // opcode shadow
  logic [7:0]   hi_q, hi_d;       // data high byte shadow
  logic [7:0]   cmd_q, cmd_d;
  logic [15:0]  data_q, data_d;
  logic         cmd_rdy_q, cmd_rdy_d;

  logic [7:0]   hold_q, hold_d;   // response byte waiting for the UART
  logic         resp_pend_q, resp_pend_d;
  logic         tx_busy_q, tx_busy_d;
  logic         trmt_q, trmt_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         resp_sent_q, resp_sent_d;

  logic         timeout_hit;

  // Every presented byte is consumed in the cycle it appears.
  assign clr_rx_rdy = rx_rdy;

`ifdef CMD_FRAME_TIMEOUT_EN
  logic frm_err_q, frm_err_d;

  cmd_frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != IDLE),
    .clr    (rx_rdy),
    .expired(timeout_hit)
  );

  assign frm_err_d = timeout_hit;

  // One-cycle error pulse for an abandoned partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= frm_err_d;
    end
  end

  assign frm_err = frm_err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign frm_err            = 1'b0;
`endif

  // Receive path: walk the frame, publish on the third byte; a timeout
  // drops the open frame but a byte arriving with it starts a new one.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q && !clr_cmd_rdy;
    if (timeout_hit) begin
      state_d = IDLE;
      if (rx_rdy) begin
        op_d    = rx_data;
        state_d = WAIT_HI;
      end
    end else if (rx_rdy) begin
      case (state_q)
        IDLE: begin
          op_d    = rx_data;
          state_d = WAIT_HI;
        end
        WAIT_HI: begin
          hi_d    = rx_data;
          state_d = WAIT_LO;
        end
        WAIT_LO: begin
          cmd_d     = op_q;
          data_d    = {hi_q, rx_data};
          cmd_rdy_d = 1'b1;   // completion beats a simultaneous clear
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Transmit path: hand a pending byte to an idle UART, retire on tx_done.
  // A send_resp always lands in the holding register, even during dispatch.
  always_comb begin
    hold_d      = hold_q;
    resp_pend_d = resp_pend_q;
    tx_busy_d   = tx_busy_q;
    trmt_d      = 1'b0;
    tx_data_d   = tx_data_q;
    resp_sent_d = 1'b0;
    if (resp_pend_q && !tx_busy_q) begin
      trmt_d      = 1'b1;
      tx_data_d   = hold_q;
      resp_pend_d = 1'b0;
      tx_busy_d   = 1'b1;
    end
    if (tx_done && tx_busy_q) begin
      tx_busy_d   = 1'b0;
      resp_sent_d = 1'b1;
    end
    if (send_resp) begin
      hold_d      = resp;
      resp_pend_d = 1'b1;
    end
  end

  // State registers for both paths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      hi_q        <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      cmd_rdy_q   <= 1'b0;
      hold_q      <= '0;
      resp_pend_q <= 1'b0;
      tx_busy_q   <= 1'b0;
      trmt_q      <= 1'b0;
      tx_data_q   <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      cmd_rdy_q   <= cmd_rdy_d;
      hold_q      <= hold_d;
      resp_pend_q <= resp_pend_d;
      tx_busy_q   <= tx_busy_d;
      trmt_q      <= trmt_d;
      tx_data_q   <= tx_data_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign cmd       = cmd_q;
  assign data      = data_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_sent = resp_sent_q;

endmodule
